// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) helpers and width constants for the AES MixColumns datapath.
// Arithmetic is modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
package aes_gf_pkg;

  localparam int          BYTE_W      = 8;
  localparam int          ROWS        = 4;
  localparam int          COL_W       = BYTE_W * ROWS;
  localparam logic [7:0]  AES_GF_POLY = 8'h1B;

  localparam logic MIX_FWD = 1'b0;
  localparam logic MIX_INV = 1'b1;

  // Multiples of one state byte; every MixColumns coefficient is an XOR of these.
  typedef struct packed {
    logic [BYTE_W-1:0] x8;
    logic [BYTE_W-1:0] x4;
    logic [BYTE_W-1:0] x2;
    logic [BYTE_W-1:0] x1;
  } byte_mults_t;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? AES_GF_POLY : 8'h00);
  endfunction

  function automatic byte_mults_t expand_byte(input logic [BYTE_W-1:0] b);
    byte_mults_t m;
    m.x1 = b;
    m.x2 = xtime(b);
    m.x4 = xtime(m.x2);
    m.x8 = xtime(m.x4);
    return m;
  endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Combinational MixColumns / InvMixColumns for one 32-bit column, built from
// precomputed {a,2a,4a,8a} per byte so only XORs remain here.
module aes_mix_single_column
  import aes_gf_pkg::*;
(
  input  byte_mults_t [ROWS-1:0] mults,
  input  logic                   inv,
  output logic [COL_W-1:0]       col
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [BYTE_W-1:0] fwd_b;
    logic [BYTE_W-1:0] inv_b;

    // fwd: 2a0 ^ 3a1 ^ a2 ^ a3;  inv: 0E a0 ^ 0B a1 ^ 0D a2 ^ 09 a3
    assign fwd_b = mults[r].x2
                 ^ mults[(r+1)%ROWS].x2 ^ mults[(r+1)%ROWS].x1
                 ^ mults[(r+2)%ROWS].x1
                 ^ mults[(r+3)%ROWS].x1;

    assign inv_b = mults[r].x8 ^ mults[r].x4 ^ mults[r].x2
                 ^ mults[(r+1)%ROWS].x8 ^ mults[(r+1)%ROWS].x2 ^ mults[(r+1)%ROWS].x1
                 ^ mults[(r+2)%ROWS].x8 ^ mults[(r+2)%ROWS].x4 ^ mults[(r+2)%ROWS].x1
                 ^ mults[(r+3)%ROWS].x8 ^ mults[(r+3)%ROWS].x1;

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
      col[BYTE_W*r +: BYTE_W] = fwd_b;
      unique case (inv)
        MIX_FWD: col[BYTE_W*r +: BYTE_W] = fwd_b;
        MIX_INV: col[BYTE_W*r +: BYTE_W] = inv_b;
        default: col[BYTE_W*r +: BYTE_W] = fwd_b;
      endcase
    end
  end

endmodule

// File: rtl/aes_mix_columns_pipe.sv
// Pipelined, back-pressured AES MixColumns/InvMixColumns over NUM_COLS columns.
// Optional macro AES_MIX_BYPASS_EN adds inBypass to pass a beat through unchanged.
module aes_mix_columns_pipe
  import aes_gf_pkg::*;
#(
  parameter int NUM_COLS    = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic                    inInv,
`ifdef AES_MIX_BYPASS_EN
  input  logic                    inBypass,
`endif
  input  logic [TAG_W-1:0]        inTag,
  input  logic [32*NUM_COLS-1:0]  inData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [TAG_W-1:0]        outTag,
  output logic [32*NUM_COLS-1:0]  outData
);

  byte_mults_t [NUM_COLS-1:0][ROWS-1:0] in_mults;
  byte_mults_t [NUM_COLS-1:0][ROWS-1:0] mix_mults;
  logic [NUM_COLS-1:0][COL_W-1:0]       mix_col;
  logic [32*NUM_COLS-1:0]               mix_data;
  logic                                 mix_valid;
  logic                                 mix_inv;
  logic                                 mix_byp;
  logic [TAG_W-1:0]                     mix_tag;
  logic                                 in_byp;
  logic                                 out_free;

`ifdef AES_MIX_BYPASS_EN
  assign in_byp = inBypass;
`else
  assign in_byp = 1'b0;
`endif

  assign out_free = !outValid || outReady;

  always_comb begin
    in_mults = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        in_mults[c][r] = expand_byte(inData[COL_W*c + BYTE_W*r +: BYTE_W]);
      end
    end
  end

  if (PIPE_STAGES == 2) begin : g_two
    logic                                 s1_valid;
    logic                                 s1_inv;
    logic                                 s1_byp;
    logic [TAG_W-1:0]                     s1_tag;
    byte_mults_t [NUM_COLS-1:0][ROWS-1:0] s1_mults;
    logic                                 in_fire;

    assign in_fire = inValid && inReady;
    // Stage 1 frees whenever the output register frees in the same cycle.
    assign inReady = !s1_valid || out_free;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (!rstN) begin
        s1_valid <= 1'b0;
      end else if (inReady) begin
        s1_valid <= inValid;
      end
    end

    // NOTE: payload registers have no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
      if (in_fire) begin
        s1_mults <= in_mults;
        s1_inv   <= inInv;
        s1_byp   <= in_byp;
        s1_tag   <= inTag;
      end
    end

    assign mix_valid = s1_valid;
    assign mix_mults = s1_mults;
    assign mix_inv   = s1_inv;
    assign mix_byp   = s1_byp;
    assign mix_tag   = s1_tag;
  end else if (PIPE_STAGES == 1) begin : g_one
    assign inReady   = out_free;
    assign mix_valid = inValid;
    assign mix_mults = in_mults;
    assign mix_inv   = inInv;
    assign mix_byp   = in_byp;
    assign mix_tag   = inTag;
  end else begin : g_bad
    $error("aes_mix_columns_pipe: PIPE_STAGES must be 1 or 2");
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    aes_mix_single_column u_col (
      .mults (mix_mults[c]),
      .inv   (mix_inv),
      .col   (mix_col[c])
    );
  end

  // Bypassed beats reuse the registered x1 copy, so no extra data storage is needed.
  always_comb begin
    mix_data = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      mix_data[COL_W*c +: COL_W] = mix_byp
        ? {mix_mults[c][3].x1, mix_mults[c][2].x1, mix_mults[c][1].x1, mix_mults[c][0].x1}
        : mix_col[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      outValid <= 1'b0;
      outTag   <= '0;
      outData  <= '0;
    end else if (out_free) begin
      outValid <= mix_valid;
      if (mix_valid) begin
        outTag  <= mix_tag;
        outData <= mix_data;
      end
    end
  end

endmodule

// File: tb/tb_aes_mix_columns_pipe.sv
// Self-checking bench: drives a PIPE_STAGES=1 (index 0) and a PIPE_STAGES=2 (index 1)
// instance and checks both against a GF(2^8) multiply reference model.
module tb_aes_mix_columns_pipe;

  typedef struct packed {
    logic [3:0]   tag;
    logic [127:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic         in_inv    [2];
  logic         in_byp    [2];
  logic [3:0]   in_tag    [2];
  logic [127:0] in_data   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [3:0]   out_tag   [2];
  logic [127:0] out_data  [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  beat_t        exp_q  [2][$];
  logic [127:0] rt_ref [2][$];
  logic [127:0] cap    [2][$];
  bit           rt_mode = 1'b0;
  bit           track = 1'b0;
  bit           stall [2];
  logic [131:0] held  [2];
  bit           fired [2];
  int           n_in  [2];
  int           first_in [2];
  int           first_out[2];
  int           last_out [2];
  int           n_out    [2];
  logic [127:0] st [1000];

  always #5 clk = ~clk;

  aes_mix_columns_pipe #(.NUM_COLS(4), .PIPE_STAGES(1), .TAG_W(4)) dut1 (
    .clk(clk), .rstN(rst_n), .inValid(in_valid[0]), .inReady(in_ready[0]),
    .inInv(in_inv[0]),
`ifdef AES_MIX_BYPASS_EN
    .inBypass(in_byp[0]),
`endif
    .inTag(in_tag[0]), .inData(in_data[0]), .outValid(out_valid[0]),
    .outReady(out_ready[0]), .outTag(out_tag[0]), .outData(out_data[0])
  );

  aes_mix_columns_pipe #(.NUM_COLS(4), .PIPE_STAGES(2), .TAG_W(4)) dut2 (
    .clk(clk), .rstN(rst_n), .inValid(in_valid[1]), .inReady(in_ready[1]),
    .inInv(in_inv[1]),
`ifdef AES_MIX_BYPASS_EN
    .inBypass(in_byp[1]),
`endif
    .inTag(in_tag[1]), .inData(in_data[1]), .outValid(out_valid[1]),
    .outReady(out_ready[1]), .outTag(out_tag[1]), .outData(out_data[1])
  );

  // Shift-and-add multiply in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
    logic [7:0]   fc [4];
    logic [7:0]   ic [4];
    logic [7:0]   acc;
    logic [127:0] o;
    fc = '{8'h02, 8'h03, 8'h01, 8'h01};
    ic = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    o  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(inv ? ic[k] : fc[k], s[32*c + 8*((r+k)%4) +: 8]);
        o[32*c + 8*r +: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input int d, input logic [131:0] obs,
                       input logic [131:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d: observed %h expected %h", name, d, obs, exp);
    end
  endtask

  task automatic new_beat(input int d);
    in_valid[d] = 1'b1;
    in_inv[d]   = 1'($urandom_range(0, 1));
    in_byp[d]   = 1'b0;
    in_tag[d]   = 4'($urandom);
    in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One clock: sample handshakes 1 unit after the input-drive edge, then advance.
  task automatic tick();
    beat_t e;
    #1;
    for (int d = 0; d < 2; d++) begin
      fired[d] = 1'b0;
      if (rst_n !== 1'b1) begin
        stall[d] = 1'b0;
        continue;
      end
      if (stall[d]) begin
        check("hold_valid", d, 132'(out_valid[d]), 132'd1);
        check("hold_beat", d, {out_tag[d], out_data[d]}, held[d]);
      end
      if (out_valid[d] === 1'b1 && out_ready[d]) begin
        cap[d].push_back(out_data[d]);
        if (track) begin
          if (first_out[d] < 0) first_out[d] = cyc;
          last_out[d] = cyc;
          n_out[d]++;
        end
        if (exp_q[d].size() == 0) begin
          check("queued_beats", d, 132'(exp_q[d].size()), 132'd1);
        end else begin
          e = exp_q[d].pop_front();
          check("beat", d, {out_tag[d], out_data[d]}, e);
        end
      end
      if (in_valid[d] && in_ready[d] === 1'b1) begin
        fired[d] = 1'b1;
        n_in[d]++;
        if (track && first_in[d] < 0) first_in[d] = cyc;
        e.tag  = in_tag[d];
        e.data = rt_mode ? rt_ref[d].pop_front()
               : (in_byp[d] ? in_data[d] : mix_ref(in_data[d], in_inv[d]));
        exp_q[d].push_back(e);
      end
      stall[d] = (out_valid[d] === 1'b1) && !out_ready[d];
      held[d]  = {out_tag[d], out_data[d]};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    for (int i = 0; i < 50 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) tick();
    for (int d = 0; d < 2; d++) check("drain_left", d, 132'(exp_q[d].size()), 132'd0);
  endtask

  task automatic start_track();
    track = 1'b1;
    for (int d = 0; d < 2; d++) begin
      first_in[d] = -1; first_out[d] = -1; last_out[d] = -1; n_out[d] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_inv[d] = 1'b0; in_byp[d] = 1'b0; in_tag[d] = '0;
      in_data[d] = '0; out_ready[d] = 1'b0; stall[d] = 1'b0; n_in[d] = 0;
    end
    @(negedge clk);
    repeat (3) tick();

    // Reset state.
    for (int d = 0; d < 2; d++) begin
      check("rst_out_valid", d, 132'(out_valid[d]), 132'd0);
      check("rst_out_beat", d, {out_tag[d], out_data[d]}, 132'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check("rst_in_ready", d, 132'(in_ready[d]), 132'd1);
    @(negedge clk);

    // Known column vectors, forward then inverse.
    for (int d = 0; d < 2; d++) begin
      cap[d].delete();
      out_ready[d] = 1'b1;
      in_valid[d]  = 1'b1;
      in_inv[d]    = 1'b0;
      in_tag[d]    = 4'h3;
      in_data[d]   = {32'hC6C6C6C6, 32'h5C220AF2, 32'h455313DB, 32'h455313DB};
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      in_inv[d]  = 1'b1;
      in_tag[d]  = 4'hC;
      in_data[d] = {4{32'hBCA14D8E}};
    end
    tick();
    drain();
    for (int d = 0; d < 2; d++) begin
      check("fixed_count", d, 132'(cap[d].size()), 132'd2);
      if (cap[d].size() == 2) begin
        check("fixed_fwd", d, 132'(cap[d][0]),
              132'({32'hC6C6C6C6, 32'h9D58DC9F, 32'hBCA14D8E, 32'hBCA14D8E}));
        check("fixed_inv", d, 132'(cap[d][1]), 132'({4{32'h455313DB}}));
      end
    end

    // Throughput and latency: 16 back-to-back beats.
    start_track();
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 2; d++) new_beat(d);
      tick();
    end
    drain();
    track = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("latency", d, 132'(first_out[d] - first_in[d]), 132'(d + 1));
      check("no_gaps", d, 132'(last_out[d] - first_out[d]), 132'd15);
      check("beats_out", d, 132'(n_out[d]), 132'd16);
    end

    // Back-pressure: fill, verify stall, then release with accept+emit together.
    for (int d = 0; d < 2; d++) begin
      in_valid[1-d]  = 1'b0;
      out_ready[d]   = 1'b0;
      n_in[d]        = 0;
      new_beat(d);
      for (int i = 0; i < 6; i++) begin
        tick();
        if (fired[d]) new_beat(d);
      end
      check("fill_accepts", d, 132'(n_in[d]), 132'(d + 1));
      check("full_in_ready", d, 132'(in_ready[d]), 132'd0);
      out_ready[d] = 1'b1;
      #1;
      check("release_in_ready", d, 132'(in_ready[d]), 132'd1);
      check("release_out_valid", d, 132'(out_valid[d]), 132'd1);
      for (int i = 0; i < 5; i++) begin
        tick();
        if (fired[d]) new_beat(d);
      end
      drain();
    end

    // Random valid/ready traffic with mixed modes.
    for (int d = 0; d < 2; d++) fired[d] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (fired[d] || !in_valid[d]) begin
          new_beat(d);
          in_valid[d] = ($urandom_range(0, 3) != 0);
        end
        out_ready[d] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    drain();

    // Round trip: 1000 random states forward, then their outputs inverse.
    for (int i = 0; i < 1000; i++) st[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int d = 0; d < 2; d++) cap[d].delete();
    for (int i = 0; i < 1000; i++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d] = 1'b1; in_inv[d] = 1'b0; in_tag[d] = 4'(i); in_data[d] = st[i];
      end
      tick();
    end
    drain();
    for (int d = 0; d < 2; d++) begin
      check("rt_fwd_count", d, 132'(cap[d].size()), 132'd1000);
      rt_ref[d].delete();
      for (int i = 0; i < 1000; i++) rt_ref[d].push_back(st[i]);
    end
    rt_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d] = 1'b1; in_inv[d] = 1'b1; in_tag[d] = 4'(i * 7);
        in_data[d]  = (i < cap[d].size()) ? cap[d][i] : '0;
      end
      tick();
    end
    drain();
    rt_mode = 1'b0;

    // Reset with beats in flight.
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 1'b0;
      new_beat(d);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int d = 0; d < 2; d++) if (fired[d]) new_beat(d);
    end
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      check("midrst_out_valid", d, 132'(out_valid[d]), 132'd0);
      check("midrst_out_beat", d, {out_tag[d], out_data[d]}, 132'd0);
      out_ready[d] = 1'b1;
    end
    repeat (6) tick();

`ifdef AES_MIX_BYPASS_EN
    // Interleaved bypass and forward beats keep order and latency.
    start_track();
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 2; d++) begin
        new_beat(d);
        in_inv[d] = 1'b0;
        in_byp[d] = 1'(i % 2);
      end
      tick();
    end
    for (int d = 0; d < 2; d++) in_byp[d] = 1'b0;
    drain();
    track = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("byp_latency", d, 132'(first_out[d] - first_in[d]), 132'(d + 1));
      check("byp_beats_out", d, 132'(n_out[d]), 132'd16);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_mix_columns_pipe.md
Name: aes_mix_columns_pipe

Overview:
Pipelined AES MixColumns / InvMixColumns engine over NUM_COLS 32-bit state columns.
- Mode is selected per transaction (forward or inverse), with a valid/ready handshake and a sideband tag carried alongside the data.
- Generalises the fixed single-constant GF(2^8) byte multipliers into a full-column, dual-mode, back-pressured datapath.
- Sits between SubBytes/ShiftRows and AddRoundKey in the round pipeline.

Parameters:
- NUM_COLS, 4: columns per beat; data width = 32*NUM_COLS (4 gives the full 128-bit state).
- PIPE_STAGES, 2: register stages, legal values 1 or 2. Any other value raises an elaboration-time error.
- TAG_W, 4: width of the sideband tag passed through unchanged.

Ports:
- clk  in  1  rising-edge clock
- rstN  in  1  synchronous reset, active low
- inValid  in  1  input beat valid
- inReady  out  1  engine can accept a beat this cycle
- inInv  in  1  0 = MixColumns, 1 = InvMixColumns
- inTag  in  TAG_W  sideband tag
- inData  in  32*NUM_COLS  state; column c = bits [32c+31:32c], row r byte = bits [32c+8r+7:32c+8r]
- outValid  out  1  output beat valid
- outReady  in  1  downstream accepts
- outTag  out  TAG_W  tag of the emitted beat
- outData  out  32*NUM_COLS  transformed state, same layout as inData

Behaviour:
- Reset: when rstN=0 at a clk edge, all stage valids clear; outValid=0, outData=0, outTag=0. inReady=1 from the first cycle after reset.
- Reset mid-operation flushes every in-flight beat; no partial beat is ever emitted.
- Transfer rules: an input transfer occurs when inValid&&inReady; an output transfer occurs when outValid&&outReady.
- Stage register k loads when it is empty or stage k+1 (or the output) frees in the same cycle. inReady = !s1Valid || s1Advance, computed combinationally back from outReady.
- Throughput: one beat/cycle with outReady held 1.
- Latency: exactly PIPE_STAGES cycles from input transfer to outValid.
- Beats are never dropped, duplicated or reordered. Data and tag must be held stable while outValid&&!outReady.
- Full pipeline with outReady=0: inReady=0. When outReady returns to 1, inReady=1 in the same cycle, and a simultaneous accept and emit occurs.
- inInv is sampled at input transfer and travels with the beat. Mixed modes on consecutive beats are legal.
- Arithmetic, over GF(2^8) mod 0x11B:
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 0x1B : 0).
  - Forward, per column: o_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
  - Inverse, per column: o_r = 0E·a_r ^ 0B·a_(r+1) ^ 0D·a_(r+2) ^ 09·a_(r+3).
- PIPE_STAGES=2:
  - Stage 1 registers, per byte, {a, 2a, 4a, 8a} plus mode and tag.
  - Stage 2 registers the mode-selected XOR combination.
- PIPE_STAGES=1: all of the above is combinational into a single output register.
- Unused input bits: none; every bit is significant.

Optional Feature:
- Macro: AES_MIX_BYPASS_EN.
- Defined:
  - Adds input port inBypass (1 bit), sampled at input transfer and travelling with the beat.
  - When set, outData equals inData unchanged (final AES round), with the same latency, so ordering is preserved.
  - inInv is ignored for bypassed beats.
- Undefined: the port does not exist and every beat is transformed.

Decomposition:
- Package aes_gf_pkg holds:
  - constant AES_GF_POLY = 8'h1B;
  - function xtime;
  - mode constants MIX_FWD=1'b0, MIX_INV=1'b1;
  - column/byte width constants.
- Sub-module aes_mix_single_column: combinational, one 32-bit column, with inputs {a,2a,4a,8a} per byte and a mode bit, and output the 32-bit mixed column. The top instantiates it NUM_COLS times and owns all registers and handshake logic.

Test Plan:
- Fwd column vector: inInv=0, column 32'h455313DB (db 13 53 45) -> 32'hBCA14D8E. Also 32'h5C220AF2 -> 32'h9D58DC9F, and 32'hC6C6C6C6 -> unchanged.
- Inverse round-trip: inInv=1 on 32'hBCA14D8E -> 32'h455313DB. Then random 128-bit states fwd→inv must return the original, 1000 beats, with the tag matching each beat.
- Throughput/latency: stream 16 beats with outReady=1. First outValid appears exactly PIPE_STAGES cycles after the first transfer, then 1 beat/cycle with no gaps; run for both PIPE_STAGES=1 and 2.
- Back-pressure: hold outReady=0 until the pipeline fills. inReady drops after PIPE_STAGES accepts, and outData/outTag stay stable. Releasing outReady gives simultaneous accept+emit with no loss, checked against a scoreboard.
- Reset mid-stream: assert rstN=0 for 1 cycle with 2 beats in flight. outValid=0 and outData=0 next cycle, and no stale beat emerges afterwards.
- Bypass (AES_MIX_BYPASS_EN builds only): interleave bypass and fwd beats. Bypass beats emerge unchanged, in order, at the same latency.
